// File: rtl/ready_issue_queue_pkg.sv
// Shared sizes and entry types for the age-ordered ready issue queue.
package ready_issue_queue_pkg;

  localparam int unsigned IQ_ENTRY_NUM      = 8;
  localparam int unsigned IQ_IDX_WIDTH      = $clog2(IQ_ENTRY_NUM);
  localparam int unsigned IQ_PTR_WIDTH      = IQ_IDX_WIDTH + 1;
  localparam int unsigned IQ_DISPATCH_WIDTH = 2;
  localparam int unsigned IQ_WAKEUP_WIDTH   = 2;
  localparam int unsigned IQ_SRC_OP_NUM     = 2;
  localparam int unsigned IQ_REG_WIDTH      = 6;
  localparam int unsigned IQ_PAYLOAD_WIDTH  = 16;

  // Circular pointer: low bits index the slot, MSB is the wrap bit.
  typedef logic [IQ_PTR_WIDTH-1:0] iq_ptr_path_t;

  typedef struct packed {
    logic [IQ_REG_WIDTH-1:0] tag;
    logic                    rdy;
  } iq_src_operand_t;

  typedef struct packed {
    logic                                    valid;
    logic [IQ_PAYLOAD_WIDTH-1:0]             payload;
    logic                                    dst_valid;
    logic [IQ_REG_WIDTH-1:0]                 dst;
    iq_src_operand_t [IQ_SRC_OP_NUM-1:0]     src;
  } iq_entry_t;

  // True when every source operand of the entry is ready.
  function automatic logic all_src_ready(input iq_entry_t e);
    logic r;
    r = 1'b1;
    for (int s = 0; s < int'(IQ_SRC_OP_NUM); s++) begin
      r = r & e.src[s].rdy;
    end
    return r;
  endfunction

endpackage

// File: rtl/ready_issue_queue_age_selector.sv
// Oldest-first selector: rotate requests so head is bit 0, pick lowest, rotate back.
module ready_age_selector
  import ready_issue_queue_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = IQ_ENTRY_NUM,
  parameter int unsigned IDX_WIDTH = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0] request,
  input  logic [IDX_WIDTH-1:0] head,
  output logic [ENTRY_NUM-1:0] grant,
  output logic                 found
);

  logic [ENTRY_NUM-1:0] rotated;
  logic [ENTRY_NUM-1:0] oldest;

  // Rotate by head, isolate the lowest set bit, rotate back to slot order.
  always_comb begin
    rotated = '0;
    grant   = '0;
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      rotated[i] = request[IDX_WIDTH'(i) + head];
    end
    oldest = rotated & (~rotated + ENTRY_NUM'(1));
    for (int i = 0; i < int'(ENTRY_NUM); i++) begin
      grant[IDX_WIDTH'(i) + head] = oldest[i];
    end
    found = |request;
  end

endmodule

// File: rtl/ready_issue_queue.sv
// Age-ordered issue queue: tracks operand readiness and offers the oldest ready op.
module ready_issue_queue
  import ready_issue_queue_pkg::*;
(
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        flush,
  input  logic [IQ_DISPATCH_WIDTH-1:0]                                dispatch,
  input  logic [IQ_DISPATCH_WIDTH-1:0][IQ_PAYLOAD_WIDTH-1:0]          dispatchedPayload,
  input  logic [IQ_DISPATCH_WIDTH-1:0]                                dispatchedDstValid,
  input  logic [IQ_DISPATCH_WIDTH-1:0][IQ_REG_WIDTH-1:0]              dispatchedDstRegNum,
  input  logic [IQ_DISPATCH_WIDTH-1:0][IQ_SRC_OP_NUM-1:0][IQ_REG_WIDTH-1:0] dispatchedSrcRegNum,
  input  logic [IQ_DISPATCH_WIDTH-1:0][IQ_SRC_OP_NUM-1:0]             dispatchedSrcReady,
  output logic                                                        dispatchReady,
  input  logic [IQ_WAKEUP_WIDTH-1:0]                                  wakeup,
  input  logic [IQ_WAKEUP_WIDTH-1:0]                                  wakeupDstValid,
  input  logic [IQ_WAKEUP_WIDTH-1:0][IQ_REG_WIDTH-1:0]                wakeupDstRegNum,
  output logic                                                        issueValid,
  input  logic                                                        issueGrant,
  output logic [IQ_PAYLOAD_WIDTH-1:0]                                 issuePayload,
  output logic                                                        issueDstValid,
  output logic [IQ_REG_WIDTH-1:0]                                     issueDstRegNum
);

  iq_entry_t    entries   [IQ_ENTRY_NUM];
  iq_entry_t    entries_n [IQ_ENTRY_NUM];
  iq_ptr_path_t head, tail, head_n, tail_n;
  iq_ptr_path_t occupancy, free_slots;

  logic [IQ_ENTRY_NUM-1:0] request;
  logic [IQ_ENTRY_NUM-1:0] grant;
  logic [IQ_ENTRY_NUM-1:0] sel;
  logic                    found;
  logic                    issue_fire;
  logic                    head_stop;
  logic [IQ_IDX_WIDTH-1:0] slot;

  // Occupancy counts holes too; space is granted per whole dispatch group.
  always_comb begin
    occupancy     = tail - head;
    free_slots    = iq_ptr_path_t'(IQ_ENTRY_NUM) - occupancy;
    dispatchReady = !rst && (free_slots >= iq_ptr_path_t'(IQ_DISPATCH_WIDTH));
  end

  // Candidates are judged on registered readiness only (one-cycle wakeup latency).
  always_comb begin
    request = '0;
    for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
      request[i] = entries[i].valid && all_src_ready(entries[i]);
    end
  end

  ready_age_selector #(
    .ENTRY_NUM (IQ_ENTRY_NUM),
    .IDX_WIDTH (IQ_IDX_WIDTH)
  ) u_age_selector (
    .request (request),
    .head    (head[IQ_IDX_WIDTH-1:0]),
    .grant   (grant),
    .found   (found)
  );

  // Offer the selected entry; all issue outputs read zero when nothing is offered.
  always_comb begin
    issueValid     = found && !rst;
    issue_fire     = issueValid && issueGrant;
    sel            = issueValid ? grant : '0;
    issuePayload   = '0;
    issueDstValid  = 1'b0;
    issueDstRegNum = '0;
    for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
      if (sel[i]) begin
        issuePayload   = issuePayload   | entries[i].payload;
        issueDstValid  = issueDstValid  | entries[i].dst_valid;
        issueDstRegNum = issueDstRegNum | entries[i].dst;
      end
    end
  end

  // Next state: wakeup, issue invalidation, in-order dispatch, then head reclaim.
  always_comb begin
    entries_n = entries;
    tail_n    = tail;
    head_n    = head;
    head_stop = 1'b0;
    slot      = '0;

    for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
      for (int s = 0; s < int'(IQ_SRC_OP_NUM); s++) begin
        for (int k = 0; k < int'(IQ_WAKEUP_WIDTH); k++) begin
          if (entries[i].valid && wakeup[k] && wakeupDstValid[k] &&
              (wakeupDstRegNum[k] == entries[i].src[s].tag)) begin
            entries_n[i].src[s].rdy = 1'b1;
          end
        end
      end
    end

    if (issue_fire) begin
      for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
        if (sel[i]) begin
          entries_n[i].valid = 1'b0;
        end
      end
    end

    if (dispatchReady) begin
      for (int l = 0; l < int'(IQ_DISPATCH_WIDTH); l++) begin
        if (dispatch[l]) begin
          slot                       = tail_n[IQ_IDX_WIDTH-1:0];
          entries_n[slot].valid      = 1'b1;
          entries_n[slot].payload    = dispatchedPayload[l];
          entries_n[slot].dst_valid  = dispatchedDstValid[l];
          entries_n[slot].dst        = dispatchedDstRegNum[l];
          for (int s = 0; s < int'(IQ_SRC_OP_NUM); s++) begin
            entries_n[slot].src[s].tag = dispatchedSrcRegNum[l][s];
            entries_n[slot].src[s].rdy = dispatchedSrcReady[l][s];
            for (int k = 0; k < int'(IQ_WAKEUP_WIDTH); k++) begin
              if (wakeup[k] && wakeupDstValid[k] &&
                  (wakeupDstRegNum[k] == dispatchedSrcRegNum[l][s])) begin
                entries_n[slot].src[s].rdy = 1'b1;
              end
            end
          end
          tail_n = tail_n + iq_ptr_path_t'(1);
        end
      end
    end

    for (int j = 0; j < int'(IQ_ENTRY_NUM); j++) begin
      if (!head_stop) begin
        if ((head_n == tail_n) || entries_n[head_n[IQ_IDX_WIDTH-1:0]].valid) begin
          head_stop = 1'b1;
        end else begin
          head_n = head_n + iq_ptr_path_t'(1);
        end
      end
    end
  end

  // State register; reset and flush both empty the queue and rewind the pointers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
        entries[i] <= '0;
      end
    end else begin
      head <= head_n;
      tail <= tail_n;
      for (int i = 0; i < int'(IQ_ENTRY_NUM); i++) begin
        entries[i] <= entries_n[i];
      end
    end
  end

endmodule

// File: tb/tb_ready_issue_queue.sv
// Self-checking bench for ready_issue_queue: vector table plus issue-order scoreboard.
module tb_ready_issue_queue;
  import ready_issue_queue_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  logic [IQ_DISPATCH_WIDTH-1:0]                                       dispatch;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_PAYLOAD_WIDTH-1:0]                 dispatchedPayload;
  logic [IQ_DISPATCH_WIDTH-1:0]                                       dispatchedDstValid;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_REG_WIDTH-1:0]                     dispatchedDstRegNum;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_SRC_OP_NUM-1:0][IQ_REG_WIDTH-1:0]  dispatchedSrcRegNum;
  logic [IQ_DISPATCH_WIDTH-1:0][IQ_SRC_OP_NUM-1:0]                    dispatchedSrcReady;
  logic                                                               dispatchReady;
  logic [IQ_WAKEUP_WIDTH-1:0]                                         wakeup;
  logic [IQ_WAKEUP_WIDTH-1:0]                                         wakeupDstValid;
  logic [IQ_WAKEUP_WIDTH-1:0][IQ_REG_WIDTH-1:0]                       wakeupDstRegNum;
  logic                                                               issueValid;
  logic                                                               issueGrant;
  logic [IQ_PAYLOAD_WIDTH-1:0]                                        issuePayload;
  logic                                                               issueDstValid;
  logic [IQ_REG_WIDTH-1:0]                                            issueDstRegNum;

  ready_issue_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .dispatch            (dispatch),
    .dispatchedPayload   (dispatchedPayload),
    .dispatchedDstValid  (dispatchedDstValid),
    .dispatchedDstRegNum (dispatchedDstRegNum),
    .dispatchedSrcRegNum (dispatchedSrcRegNum),
    .dispatchedSrcReady  (dispatchedSrcReady),
    .dispatchReady       (dispatchReady),
    .wakeup              (wakeup),
    .wakeupDstValid      (wakeupDstValid),
    .wakeupDstRegNum     (wakeupDstRegNum),
    .issueValid          (issueValid),
    .issueGrant          (issueGrant),
    .issuePayload        (issuePayload),
    .issueDstValid       (issueDstValid),
    .issueDstRegNum      (issueDstRegNum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [IQ_PAYLOAD_WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [1:0]  rdy;
    logic [5:0]  tag0;
    logic [5:0]  tag1;
    logic        wk_valid;
    logic        wk_dst_valid;
    logic        wk_port;
    logic [5:0]  wk_tag;
    logic [15:0] payload;
    logic        exp_issue;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic clr();
    dispatch            = '0;
    dispatchedPayload   = '0;
    dispatchedDstValid  = '0;
    dispatchedDstRegNum = '0;
    dispatchedSrcRegNum = '0;
    dispatchedSrcReady  = '0;
    wakeup              = '0;
    wakeupDstValid      = '0;
    wakeupDstRegNum     = '0;
    issueGrant          = 1'b0;
    flush               = 1'b0;
  endtask

  task automatic drive_lane(input int l, input logic [15:0] pl, input logic [1:0] rdy,
                            input logic [5:0] t0, input logic [5:0] t1,
                            input logic dv, input logic [5:0] dst);
    dispatch[l]               = 1'b1;
    dispatchedPayload[l]      = pl;
    dispatchedDstValid[l]     = dv;
    dispatchedDstRegNum[l]    = dst;
    dispatchedSrcRegNum[l][0] = t0;
    dispatchedSrcRegNum[l][1] = t1;
    dispatchedSrcReady[l]     = rdy;
  endtask

  task automatic wake(input int k, input logic [5:0] tag);
    wakeup[k]          = 1'b1;
    wakeupDstValid[k]  = 1'b1;
    wakeupDstRegNum[k] = tag;
  endtask

  // Scoreboard compare for any granted issue, then advance to the next negedge.
  task automatic tick();
    #1;
    if (issueValid && issueGrant && !flush && !rst) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_issue: actual %0h required none", issuePayload);
      end else begin
        check("issue_order", 32'(issuePayload), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_flush();
    clr();
    flush = 1'b1;
    tick();
    clr();
  endtask

  task automatic grant_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clr();
      issueGrant = 1'b1;
      tick();
    end
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 rdy    tag0   tag1   wkv   wkdv  port  wktag  payload    exp
    vecs[0] = '{2'b11, 6'd1,  6'd2,  1'b0, 1'b0, 1'b0, 6'd0,  16'h0A01, 1'b1};
    vecs[1] = '{2'b01, 6'd1,  6'd7,  1'b1, 1'b1, 1'b0, 6'd7,  16'h0A02, 1'b1};
    vecs[2] = '{2'b01, 6'd1,  6'd7,  1'b1, 1'b1, 1'b0, 6'd8,  16'h0A03, 1'b0};
    vecs[3] = '{2'b00, 6'd3,  6'd4,  1'b1, 1'b1, 1'b0, 6'd3,  16'h0A04, 1'b0};
    vecs[4] = '{2'b01, 6'd1,  6'd9,  1'b1, 1'b0, 1'b0, 6'd9,  16'h0A05, 1'b0};
    vecs[5] = '{2'b10, 6'd12, 6'd1,  1'b1, 1'b1, 1'b1, 6'd12, 16'h0A06, 1'b1};
    vecs[6] = '{2'b00, 6'd20, 6'd20, 1'b1, 1'b1, 1'b0, 6'd20, 16'h0A07, 1'b1};

    // Reset: outputs low while rst is high, dispatch ignored.
    rst = 1'b1;
    clr();
    @(negedge clk);
    drive_lane(0, 16'h0BAD, 2'b11, 6'd0, 6'd0, 1'b0, 6'd0);
    #1;
    check("rst_issue_valid", 32'(issueValid), 32'd0);
    check("rst_dispatch_ready", 32'(dispatchReady), 32'd0);
    tick();
    #1;
    check("rst_issue_valid2", 32'(issueValid), 32'd0);
    check("rst_dispatch_ready2", 32'(dispatchReady), 32'd0);
    rst = 1'b0;
    clr();
    #1;
    check("post_rst_dispatch_ready", 32'(dispatchReady), 32'd1);
    check("post_rst_issue_valid", 32'(issueValid), 32'd0);
    check("idle_payload_zero", 32'(issuePayload), 32'd0);

    // Vector table: single op with ready/wakeup pattern, issue expected next cycle or not.
    for (int v = 0; v < 7; v++) begin
      clr();
      issueGrant = 1'b1;
      drive_lane(0, vecs[v].payload, vecs[v].rdy, vecs[v].tag0, vecs[v].tag1, 1'b0, 6'd0);
      wakeup[vecs[v].wk_port]          = vecs[v].wk_valid;
      wakeupDstValid[vecs[v].wk_port]  = vecs[v].wk_dst_valid;
      wakeupDstRegNum[vecs[v].wk_port] = vecs[v].wk_tag;
      if (vecs[v].exp_issue) exp_q.push_back(vecs[v].payload);
      #1;
      check($sformatf("tbl%0d_dispatch_ready", v), 32'(dispatchReady), 32'd1);
      tick();
      clr();
      issueGrant = 1'b1;
      #1;
      check($sformatf("tbl%0d_issue_valid", v), 32'(issueValid), 32'(vecs[v].exp_issue));
      tick();
      do_flush();
    end

    // Ready at dispatch: offered the next cycle, cleared after the grant edge.
    clr();
    issueGrant = 1'b1;
    drive_lane(0, 16'h0011, 2'b11, 6'd1, 6'd2, 1'b1, 6'd17);
    exp_q.push_back(16'h0011);
    #1;
    check("rd_same_cycle_invalid", 32'(issueValid), 32'd0);
    tick();
    clr();
    issueGrant = 1'b1;
    #1;
    check("rd_issue_valid", 32'(issueValid), 32'd1);
    check("rd_payload", 32'(issuePayload), 32'h0011);
    check("rd_dst", 32'(issueDstRegNum), 32'd17);
    tick();
    #1;
    check("rd_cleared", 32'(issueValid), 32'd0);

    // Wakeup path: tag 5 woken two cycles after dispatch, issue only the cycle after.
    clr();
    issueGrant = 1'b1;
    drive_lane(0, 16'h0022, 2'b10, 6'd5, 6'd1, 1'b0, 6'd0);
    tick();
    clr();
    issueGrant = 1'b1;
    #1;
    check("wk_wait", 32'(issueValid), 32'd0);
    tick();
    clr();
    issueGrant = 1'b1;
    wake(0, 6'd5);
    #1;
    check("wk_same_cycle", 32'(issueValid), 32'd0);
    exp_q.push_back(16'h0022);
    tick();
    clr();
    issueGrant = 1'b1;
    #1;
    check("wk_issue_valid", 32'(issueValid), 32'd1);
    check("wk_payload", 32'(issuePayload), 32'h0022);
    tick();
    #1;
    check("wk_cleared", 32'(issueValid), 32'd0);

    // Age order: A not ready, then B and C ready; B held without grant; order B, C, A.
    clr();
    drive_lane(0, 16'h000A, 2'b10, 6'd10, 6'd1, 1'b0, 6'd0);
    tick();
    clr();
    drive_lane(0, 16'h000B, 2'b11, 6'd1, 6'd2, 1'b1, 6'd33);
    drive_lane(1, 16'h000C, 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
    exp_q.push_back(16'h000B);
    exp_q.push_back(16'h000C);
    tick();
    for (int h = 0; h < 2; h++) begin
      clr();
      #1;
      check($sformatf("age_hold%0d", h), 32'(issuePayload), 32'h000B);
      tick();
    end
    clr();
    issueGrant = 1'b1;
    #1;
    check("age_b_dst_valid", 32'(issueDstValid), 32'd1);
    check("age_b_dst", 32'(issueDstRegNum), 32'd33);
    tick();
    clr();
    issueGrant = 1'b1;
    wake(1, 6'd10);
    exp_q.push_back(16'h000A);
    tick();
    grant_cycles(1);
    #1;
    check("age_drained", 32'(issueValid), 32'd0);

    // An older entry becoming ready takes over the held selection.
    clr();
    drive_lane(0, 16'h00E0, 2'b10, 6'd40, 6'd1, 1'b0, 6'd0);
    drive_lane(1, 16'h00E1, 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
    tick();
    clr();
    wake(1, 6'd40);
    #1;
    check("younger_offered", 32'(issuePayload), 32'h00E1);
    tick();
    clr();
    #1;
    check("older_preempts", 32'(issuePayload), 32'h00E0);
    exp_q.push_back(16'h00E0);
    exp_q.push_back(16'h00E1);
    grant_cycles(2);
    #1;
    check("preempt_drained", 32'(issueValid), 32'd0);

    // Full and wrap: fill 8, free 2, then refill repeatedly across the wrap bit.
    do_flush();
    for (int g = 0; g < 4; g++) begin
      clr();
      drive_lane(0, 16'(16'h0100 + 2*g),     2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      drive_lane(1, 16'(16'h0100 + 2*g + 1), 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      exp_q.push_back(16'(16'h0100 + 2*g));
      exp_q.push_back(16'(16'h0100 + 2*g + 1));
      #1;
      check($sformatf("fill%0d_ready", g), 32'(dispatchReady), 32'd1);
      tick();
    end
    clr();
    #1;
    check("full_not_ready", 32'(dispatchReady), 32'd0);
    check("full_head_offer", 32'(issuePayload), 32'h0100);
    issueGrant = 1'b1;
    tick();
    clr();
    issueGrant = 1'b1;
    #1;
    check("one_free_not_ready", 32'(dispatchReady), 32'd0);
    tick();
    for (int g = 4; g < 7; g++) begin
      clr();
      #1;
      check($sformatf("wrap%0d_ready", g), 32'(dispatchReady), 32'd1);
      drive_lane(0, 16'(16'h0100 + 2*g),     2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      drive_lane(1, 16'(16'h0100 + 2*g + 1), 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      exp_q.push_back(16'(16'h0100 + 2*g));
      exp_q.push_back(16'(16'h0100 + 2*g + 1));
      tick();
      clr();
      #1;
      check($sformatf("wrap%0d_full", g), 32'(dispatchReady), 32'd0);
      grant_cycles(2);
    end
    for (int d = 0; d < 16; d++) begin
      clr();
      issueGrant = 1'b1;
      #1;
      if (!issueValid) break;
      tick();
    end
    clr();
    #1;
    check("wrap_drain_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_drain_idle", 32'(issueValid), 32'd0);

    // Flush with live entries plus same-cycle dispatch and grant.
    for (int g = 0; g < 3; g++) begin
      clr();
      drive_lane(0, 16'(16'h0200 + 2*g), 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      if (g < 2) drive_lane(1, 16'(16'h0201 + 2*g), 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      tick();
    end
    clr();
    #1;
    check("flush_live", 32'(issueValid), 32'd1);
    drive_lane(0, 16'h02F0, 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
    drive_lane(1, 16'h02F1, 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
    issueGrant = 1'b1;
    flush = 1'b1;
    tick();
    clr();
    #1;
    check("flush_issue_valid", 32'(issueValid), 32'd0);
    check("flush_dispatch_ready", 32'(dispatchReady), 32'd1);
    for (int g = 0; g < 4; g++) begin
      clr();
      #1;
      check($sformatf("post_flush_fill%0d", g), 32'(dispatchReady), 32'd1);
      drive_lane(0, 16'(16'h0300 + 2*g),     2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      drive_lane(1, 16'(16'h0300 + 2*g + 1), 2'b11, 6'd1, 6'd2, 1'b0, 6'd0);
      tick();
    end
    clr();
    #1;
    check("post_flush_full", 32'(dispatchReady), 32'd0);
    check("post_flush_head", 32'(issuePayload), 32'h0300);
    do_flush();
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ready_issue_queue.md
Name: ready_issue_queue

Overview:
- Age-ordered issue queue that consumes the per-source ready bits produced at dispatch by the ready bit table.
- Tracks the readiness of each operand against later wakeup broadcasts.
- Selects the oldest fully-ready entry for issue each cycle.
- Sits between dispatch and the register-read/execute stages of one scheduler cluster.

Parameters:
- ENTRY_NUM, 8, queue entries; power of two, at least 4.
- DISPATCH_WIDTH, 2, dispatch lanes per cycle.
- WAKEUP_WIDTH, 2, wakeup broadcast ports.
- SRC_OP_NUM, 2, source operands per entry.
- REG_NUM_BIT_WIDTH, 6, physical register tag width.
- PAYLOAD_WIDTH, 16, opaque op payload (op id plus control).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all entries.
- dispatch  in  [DISPATCH_WIDTH]x1  lane valid.
- dispatchedPayload  in  [DISPATCH_WIDTH]xPAYLOAD_WIDTH  op payload.
- dispatchedDstValid  in  [DISPATCH_WIDTH]x1  destination present.
- dispatchedDstRegNum  in  [DISPATCH_WIDTH]xREG_NUM_BIT_WIDTH  destination tag.
- dispatchedSrcRegNum  in  [DISPATCH_WIDTH][SRC_OP_NUM]xREG_NUM_BIT_WIDTH  source tags.
- dispatchedSrcReady  in  [DISPATCH_WIDTH][SRC_OP_NUM]x1  ready at dispatch; an invalid source arrives as 1.
- dispatchReady  out  1  queue can accept a full dispatch group this cycle.
- wakeup  in  [WAKEUP_WIDTH]x1  broadcast valid.
- wakeupDstValid  in  [WAKEUP_WIDTH]x1  broadcast carries a destination.
- wakeupDstRegNum  in  [WAKEUP_WIDTH]xREG_NUM_BIT_WIDTH  woken tag.
- issueValid  out  1  a selected entry is offered.
- issueGrant  in  1  downstream accepts the offered entry.
- issuePayload  out  PAYLOAD_WIDTH  selected payload.
- issueDstValid  out  1  destination present for the selected entry.
- issueDstRegNum  out  REG_NUM_BIT_WIDTH  destination tag for the selected entry.

Behaviour:
- State:
  - Circular buffer with head and tail pointers of log2(ENTRY_NUM)+1 bits; the MSB is a wrap bit.
  - Per entry: valid, payload, dst, src tags, and a srcRdy bit per operand.
  - Occupancy = tail - head, which includes holes left by issued entries.
- Reset:
  - rst at an edge gives head=tail=0 and all entries invalid.
  - While rst is high, dispatchReady=0, issueValid=0, and dispatch and wakeup are ignored.
  - Cycle after rst deasserts: dispatchReady=1, issueValid=0.
- Dispatch:
  - dispatchReady = (ENTRY_NUM - occupancy) >= DISPATCH_WIDTH; it is all-or-nothing per group.
  - Active lanes are written in lane order into consecutive slots from tail; tail advances by the number of active lanes, so holes are never created at dispatch.
  - Lanes raised while dispatchReady=0 are dropped; the bench flags this as an error.
  - srcRdy is written from dispatchedSrcReady OR a same-cycle wakeup tag match.
- Wakeup:
  - Each cycle, for every valid entry and source, srcRdy is set if any wakeup[k] && wakeupDstValid[k] && tag equals that source tag.
  - srcRdy bits are never cleared while the entry is valid.
- Select (combinational from registered state):
  - Candidate = valid entry with all srcRdy=1, taken as of the start of the cycle.
  - issueValid = any candidate exists; the chosen entry is the candidate closest to head in circular order.
  - Wakeup-to-issue latency is one cycle: a wakeup seen in cycle N makes the entry selectable in N+1, never in N.
  - When issueValid=0, the issue outputs are 0.
- Issue:
  - At the edge where issueValid && issueGrant, the selected entry is invalidated.
  - Without issueGrant, the same selection is held; it changes only when an older entry becomes ready.
- Head reclaim: at every edge, head advances over every invalid slot until it reaches the first valid slot or tail; this may cover up to ENTRY_NUM slots in one cycle.
- Simultaneous events:
  - Issue and dispatch in the same cycle are independent.
  - Freed space becomes visible in dispatchReady in the next cycle.
- Flush:
  - At the edge, all entries are invalidated and head=tail=0.
  - Same-cycle dispatch is dropped.
  - A same-cycle grant has no architectural effect.
  - flush takes priority below rst.
- Full and empty:
  - occupancy==ENTRY_NUM gives dispatchReady=0.
  - occupancy==0 gives issueValid=0.
  - Pointer wrap-around is correct across the wrap-bit toggle.

Decomposition:
- Package IssueQueueTypes holds:
  - IQ_ENTRY_NUM and IQ_PTR_WIDTH;
  - IqPtrPath;
  - IqEntry struct (valid, payload, dst, src[] with tag and rdy);
  - IqSrcOperand struct.
- Sub-module ready_age_selector:
  - Inputs: ENTRY_NUM request bits and the head index.
  - Outputs: one-hot grant for the oldest request, plus a found bit.
  - Implementation: rotate by head, priority-encode, rotate back.

Test Plan:
- Reset then idle: rst high 2 cycles -> issueValid=0, dispatchReady=0; the cycle after release, dispatchReady=1.
- Ready at dispatch: lane0 with srcReady={1,1}, payload 0x0011, issueGrant=1 -> issueValid=1 the next cycle with payload 0x0011; the entry clears after the grant edge.
- Wakeup path: dispatch src tag 5 not ready; wakeup tag 5 two cycles later -> issueValid stays 0 until the cycle after the wakeup, then 1.
- Age order: dispatch A (not ready), then B and C (ready); wake A -> issue order B, C, A; while B is offered with issueGrant=0, B is held.
- Full and wrap: ENTRY_NUM=8, dispatch 4 pairs with no grant -> dispatchReady=0 at occupancy 8; grant the head 2 -> head advances by 2 and dispatchReady=1; 3 more groups wrap tail past index 7 correctly.
- Flush mid-operation: 5 entries live plus a same-cycle dispatch and grant with flush -> next cycle head=tail=0, issueValid=0, dispatchReady=1.
